instr_encoder_loader: RTL

//  Encoder counterpart of the control-unit decoder: accepts symbolic instructions (op code + register/immediate

---
 rtl/instr_encoder_loader_if.sv | 24 ++
 rtl/instr_encoder_loader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader_if.sv
// Instruction-field stream into the encoder plus the imem write bus it drives.
// master = program source / bench side, slave = encoder side.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs symbolic instructions into 32-bit MIPS words and writes them sequentially
// into instruction memory during a start/stop delimited load session.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  err
);

    localparam logic [ADDR_W:0] CountFull = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CountLast = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CountOne  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

    state_e          state_q;
    logic [ADDR_W:0] count_q;
    logic            we_q;
    logic            err_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;

    logic            xfer;
    logic            enc_legal;
    logic            enc_rtype;
    logic [5:0]      enc_opcode;
    logic [5:0]      enc_funct;
    logic [31:0]     enc_word;

    always_comb begin
        enc_legal  = 1'b1;
        enc_rtype  = 1'b0;
        enc_opcode = 6'h00;
        enc_funct  = 6'h00;
        case (bus.in_op)
            5'd0:  begin enc_rtype = 1'b1; enc_funct = 6'h20; end
            5'd1:  begin enc_rtype = 1'b1; enc_funct = 6'h21; end
            5'd2:  begin enc_rtype = 1'b1; enc_funct = 6'h22; end
            5'd3:  begin enc_rtype = 1'b1; enc_funct = 6'h23; end
            5'd4:  begin enc_rtype = 1'b1; enc_funct = 6'h24; end
            5'd5:  begin enc_rtype = 1'b1; enc_funct = 6'h25; end
            5'd6:  begin enc_rtype = 1'b1; enc_funct = 6'h26; end
            5'd7:  begin enc_rtype = 1'b1; enc_funct = 6'h27; end
            5'd8:  begin enc_rtype = 1'b1; enc_funct = 6'h2A; end
            5'd9:  begin enc_rtype = 1'b1; enc_funct = 6'h2B; end
            5'd10: enc_opcode = 6'h23;
            5'd11: enc_opcode = 6'h2B;
            5'd12: enc_opcode = 6'h04;
            5'd13: enc_opcode = 6'h05;
            5'd14: enc_opcode = 6'h0A;
            5'd15: enc_opcode = 6'h0B;
            5'd16: enc_opcode = 6'h0C;
            5'd17: enc_opcode = 6'h0D;
            5'd18: enc_opcode = 6'h0E;
            5'd19: enc_opcode = 6'h08;
            5'd20: enc_opcode = 6'h09;
            default: enc_legal = 1'b0;
        endcase
        enc_word = enc_rtype ? {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, enc_funct}
                             : {enc_opcode, bus.in_rs, bus.in_rt, bus.in_imm};
    end

    // A start request blocks acceptance so a restart never mixes with a transfer.
    assign bus.in_ready   = (state_q == StRun) & ~start & ~reset;
    assign xfer           = bus.in_valid & bus.in_ready;

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign count          = count_q;
    assign full           = (count_q == CountFull);
    assign err            = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        count_q <= '0;
                    end
                end
                StRun: begin
                    if (start) begin
                        count_q <= '0;
                    end else begin
                        if (xfer) begin
                            if (enc_legal) begin
                                we_q    <= 1'b1;
                                addr_q  <= BASE_ADDR + (32'(count_q) << 2);
                                wdata_q <= enc_word;
                                count_q <= count_q + CountOne;
                                if (count_q == CountLast) state_q <= StFull;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        // stop overrides the move to FULL; the final word is still written
                        if (stop) state_q <= StIdle;
                    end
                end
                StFull: begin
                    if (start) begin
                        state_q <= StRun;
                        count_q <= '0;
                    end else if (stop) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
